// File: rtl/rand_pos_gen.sv
// Random position generator: a Galois LFSR perturbed by rotary-event timing,
// drawn by rejection sampling with a bounded number of attempts and a fallback.
module rand_pos_gen #(
    parameter int unsigned       OUT_W     = 6,
    parameter int unsigned       RANGE     = 48,
    parameter int unsigned       LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] TAPS      = 32'h80200003,
    parameter logic [LFSR_W-1:0] SEED      = 32'h00000001,
    parameter int unsigned       MAX_TRIES = 8,
    parameter bit                NO_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rot_event,
    input  logic             req,
    output logic [OUT_W-1:0] rand_pos,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned      ATT_W        = $clog2(MAX_TRIES + 1);
    // RANGE may equal 2^OUT_W, so range compares carry one extra bit.
    localparam logic [OUT_W:0]   RANGE_X      = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0] LAST_POS     = OUT_W'(RANGE - 1);
    localparam bit               GUARD_REPEAT = NO_REPEAT && (RANGE > 1);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t            state, state_nx;
    logic [LFSR_W-1:0] clk_count, lfsr, lfsr_stepped, lfsr_mixed, lfsr_nx;
    logic [ATT_W-1:0]  attempt;
    logic [OUT_W-1:0]  cand, folded, fallback, result;
    logic              in_range, accept, last_try, finish;

    always_comb begin
        lfsr_stepped = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        lfsr_mixed   = rot_event ? (lfsr_stepped ^ clk_count) : lfsr_stepped;
        lfsr_nx      = (lfsr_mixed == '0) ? SEED : lfsr_mixed;
    end

    always_comb begin
        cand     = lfsr[OUT_W-1:0];
        in_range = ({1'b0, cand} < RANGE_X);
        accept   = in_range && !(GUARD_REPEAT && (cand == rand_pos));
        folded   = in_range ? cand : OUT_W'({1'b0, cand} - RANGE_X);
        if (GUARD_REPEAT && (folded == rand_pos))
            fallback = (rand_pos == LAST_POS) ? '0 : rand_pos + 1'b1;
        else
            fallback = folded;
        last_try = (attempt == ATT_W'(MAX_TRIES));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = DRAW;
            DRAW:    if (accept || last_try) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == DRAW);
        finish = busy && (accept || last_try);
        result = accept ? cand : fallback;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_count <= '0;
            lfsr      <= SEED;
            attempt   <= '0;
            rand_pos  <= '0;
            valid     <= 1'b0;
        end else begin
            clk_count <= clk_count + 1'b1;
            lfsr      <= lfsr_nx;
            valid     <= finish;
            if (finish)
                rand_pos <= result;
            if ((state == IDLE) && req)
                attempt <= ATT_W'(1);
            else if (busy && !finish)
                attempt <= attempt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rand_pos_gen.sv
// Scoreboard bench for rand_pos_gen: default instance, a two-position instance
// and a narrow 8-bit LFSR instance whose draws are predicted exactly.
module tb_rand_pos_gen;

    typedef struct {
        int unsigned val_lo;
        int unsigned val_hi;
        int unsigned issue;
        int unsigned lat_lo;
        int unsigned lat_hi;
    } exp_t;

    logic clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic       rst_a = 1'b1, rot_a = 1'b0, req_a = 1'b0, valid_a, busy_a;
    logic [5:0] pos_a;
    logic       rst_b = 1'b1, rot_b = 1'b0, req_b = 1'b0, valid_b, busy_b;
    logic [1:0] pos_b;
    logic       rst_c = 1'b1, rot_c = 1'b0, req_c = 1'b0, valid_c, busy_c;
    logic [2:0] pos_c;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;
    int unsigned last_a = 0, last_b = 0, last_c = 0, nval_a = 0;

    logic [7:0] m_lfsr = 8'h01, m_cnt = 8'h00;
    logic [2:0] m_prev = 3'd0;

    rand_pos_gen dut_a (
        .clk(clk), .rst(rst_a), .rot_event(rot_a), .req(req_a),
        .rand_pos(pos_a), .valid(valid_a), .busy(busy_a)
    );

    rand_pos_gen #(.OUT_W(2), .RANGE(2)) dut_b (
        .clk(clk), .rst(rst_b), .rot_event(rot_b), .req(req_b),
        .rand_pos(pos_b), .valid(valid_b), .busy(busy_b)
    );

    rand_pos_gen #(
        .OUT_W(3), .RANGE(5), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h01),
        .MAX_TRIES(2), .NO_REPEAT(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .rot_event(rot_c), .req(req_c),
        .rand_pos(pos_c), .valid(valid_c), .busy(busy_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic unexpected(input string name, input int unsigned pos);
        checks++;
        errors++;
        $display("FAIL %s actual=valid(pos %0d) required=no valid", name, pos);
    endtask

    task automatic score(input string tag, input exp_t e, input int unsigned pos, input int unsigned last);
        chk_rng({tag, "_pos"}, pos, e.val_lo, e.val_hi);
        chk_rng({tag, "_latency"}, cyc - e.issue, e.lat_lo, e.lat_hi);
        checks++;
        if (pos == last) begin
            errors++;
            $display("FAIL %s_repeat actual=%0d required=not %0d", tag, pos, last);
        end
    endtask

    function automatic exp_t mk(input int unsigned lo, input int unsigned hi,
                                input int unsigned llo, input int unsigned lhi);
        exp_t e;
        e.val_lo = lo; e.val_hi = hi; e.issue = cyc; e.lat_lo = llo; e.lat_hi = lhi;
        return e;
    endfunction

    function automatic logic [7:0] step8(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // Monitors: pop one expectation per valid pulse.
    always @(negedge clk) begin
        if (valid_a) begin
            nval_a++;
            if (qa.size() == 0) unexpected("a_unexpected_valid", pos_a);
            else begin ea = qa.pop_front(); score("a", ea, pos_a, last_a); end
            last_a = pos_a;
        end
        if (rst_a) last_a = 0;
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (qb.size() == 0) unexpected("b_unexpected_valid", pos_b);
            else begin eb = qb.pop_front(); score("b", eb, pos_b, last_b); end
            last_b = pos_b;
        end
        if (rst_b) last_b = 0;
    end

    always @(negedge clk) begin
        if (valid_c) begin
            if (qc.size() == 0) unexpected("c_unexpected_valid", pos_c);
            else begin ec = qc.pop_front(); score("c", ec, pos_c, last_c); end
            last_c = pos_c;
        end
        if (rst_c) last_c = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances the narrow instance's reference LFSR/counter along with the clock.
    task automatic tick_c();
        logic [7:0] n;
        n = step8(m_lfsr) ^ (rot_c ? m_cnt : 8'h00);
        if (n == 8'h00) n = 8'h01;
        m_lfsr = n;
        m_cnt  = m_cnt + 8'd1;
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, g, v, lat, v0;
        bit hit;
        logic [7:0] l1, l2;
        logic [2:0] c1, c2, f;

        repeat (3) tick();
        chk_eq("a_rst_pos", pos_a, 0);
        chk_eq("a_rst_valid", valid_a, 0);
        chk_eq("a_rst_busy", busy_a, 0);
        chk_eq("a_rst_lfsr", dut_a.lfsr, 1);
        chk_eq("a_rst_count", dut_a.clk_count, 0);

        // First draw after reset: lfsr 1 -> 0x80200003, candidate 3 accepted.
        rst_a = 1'b0; req_a = 1'b1;
        qa.push_back(mk(3, 3, 2, 2));
        tick();
        req_a = 1'b0;
        chk_eq("a_first_busy", busy_a, 1);
        chk_eq("a_first_lfsr", dut_a.lfsr, 32'h80200003);
        tick();
        chk_eq("a_first_busy_done", busy_a, 0);
        chk_eq("a_first_valid", valid_a, 1);
        chk_eq("a_first_pos", pos_a, 3);
        tick();

        // Extra req during DRAW must not start a second draw.
        v0 = nval_a;
        req_a = 1'b1;
        if (!busy_a) qa.push_back(mk(0, 47, 2, 9));
        tick();
        req_a = 1'b1;
        chk_eq("a_busy_when_req_again", busy_a, 1);
        tick();
        req_a = 1'b0;
        repeat (20) tick();
        chk_eq("a_req_busy_pulses", nval_a - v0, 1);

        // Back-to-back requests with random rotary events.
        n = 0;
        for (int j = 0; j < 40000 && n < 10000; j++) begin
            req_a = 1'b1;
            rot_a = 1'($urandom_range(0, 1));
            if (!busy_a) begin
                qa.push_back(mk(0, 47, 2, 9));
                n++;
            end
            tick();
        end
        req_a = 1'b0; rot_a = 1'b0;
        chk_eq("a_bulk_requests", n, 10000);
        for (int j = 0; j < 20 && qa.size() != 0; j++) tick();
        chk_eq("a_bulk_drained", qa.size(), 0);
        tick();

        // Reset in the middle of a draw.
        req_a = 1'b1;
        qa.push_back(mk(0, 47, 2, 9));
        tick();
        req_a = 1'b0;
        chk_eq("a_midreset_busy_before", busy_a, 1);
        rst_a = 1'b1;
        qa.delete();
        tick();
        chk_eq("a_midreset_busy", busy_a, 0);
        chk_eq("a_midreset_valid", valid_a, 0);
        chk_eq("a_midreset_pos", pos_a, 0);
        chk_eq("a_midreset_lfsr", dut_a.lfsr, 1);
        chk_eq("a_midreset_count", dut_a.clk_count, 0);
        rst_a = 1'b0;
        repeat (12) tick();

        // Two positions with no-repeat: results must alternate 1,0,1,...
        rst_b = 1'b0;
        n = 0;
        for (int j = 0; j < 400 && n < 20; j++) begin
            req_b = 1'b1;
            if (!busy_b) begin
                v = (n % 2 == 0) ? 1 : 0;
                qb.push_back(mk(v, v, 2, 9));
                n++;
            end
            tick();
        end
        req_b = 1'b0;
        repeat (12) tick();
        chk_eq("b_requests", n, 20);

        // Narrow instance: exact prediction of every draw, including fallbacks.
        chk_eq("c_rst_lfsr", dut_c.lfsr, 1);
        chk_eq("c_rst_count", dut_c.clk_count, 0);
        rst_c = 1'b0;
        m_lfsr = 8'h01; m_cnt = 8'h00; m_prev = 3'd0;
        for (int k = 0; k < 150; k++) begin
            g = $urandom_range(1, 4);
            for (int j = 0; j < int'(g); j++) begin
                rot_c = 1'($urandom_range(0, 1));
                tick_c();
            end
            rot_c = 1'b0;
            chk_eq("c_lfsr_track", dut_c.lfsr, m_lfsr);
            chk_eq("c_count_track", dut_c.clk_count, m_cnt);
            chk_eq("c_idle_at_req", busy_c, 0);
            l1 = step8(m_lfsr);
            c1 = l1[2:0];
            if (c1 < 3'd5 && c1 != m_prev) begin
                v = c1; lat = 2;
            end else begin
                l2 = step8(l1);
                c2 = l2[2:0];
                lat = 3;
                if (c2 < 3'd5 && c2 != m_prev) v = c2;
                else begin
                    f = (c2 >= 3'd5) ? c2 - 3'd5 : c2;
                    if (f == m_prev) f = (m_prev == 3'd4) ? 3'd0 : m_prev + 3'd1;
                    v = f;
                end
            end
            m_prev = 3'(v);
            req_c = 1'b1;
            qc.push_back(mk(v, v, lat, lat));
            tick_c();
            req_c = 1'b0;
            tick_c();
        end

        // Zero guard: fire rot_event exactly when step(lfsr) ^ clk_count == 0.
        hit = 1'b0;
        for (int j = 0; j < 20000 && !hit; j++) begin
            if ((step8(m_lfsr) ^ m_cnt) == 8'h00) begin
                rot_c = 1'b1;
                hit = 1'b1;
            end else begin
                rot_c = 1'($urandom_range(0, 1));
            end
            tick_c();
        end
        rot_c = 1'b0;
        chk_eq("c_zero_guard_reached", hit, 1);
        if (hit) chk_eq("c_zero_guard_seed", dut_c.lfsr, 8'h01);

        repeat (12) tick();
        chk_eq("a_queue_empty", qa.size(), 0);
        chk_eq("b_queue_empty", qb.size(), 0);
        chk_eq("c_queue_empty", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
